// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared response bus and the ALU
// hookup for alu_arbiter. The slave modport is the arbiter's view; the master
// modport is the requesters plus the combinational ALU.
`timescale 1ns/1ps
interface alu_arbiter_if #(
    parameter int W = 32
);
    // Requester 0
    logic         r0_valid;
    logic         r0_ready;
    logic [5:0]   r0_fn;
    logic [W-1:0] r0_a;
    logic [W-1:0] r0_b;
    logic         r0_rsp_valid;
    logic         r0_rsp_ready;

    // Requester 1
    logic         r1_valid;
    logic         r1_ready;
    logic [5:0]   r1_fn;
    logic [W-1:0] r1_a;
    logic [W-1:0] r1_b;
    logic         r1_rsp_valid;
    logic         r1_rsp_ready;

    // Shared response payload
    logic [W-1:0] rsp_data;
    logic         rsp_z;
    logic         rsp_v;
    logic         rsp_n;
    logic         rsp_err;

    // ALU hookup
    logic [5:0]   alu_fn;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_res;
    logic         alu_z;
    logic         alu_v;
    logic         alu_n;

    logic         busy;

    modport slave (
        input  r0_valid, r0_fn, r0_a, r0_b, r0_rsp_ready,
        input  r1_valid, r1_fn, r1_a, r1_b, r1_rsp_ready,
        output r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        output rsp_data, rsp_z, rsp_v, rsp_n, rsp_err,
        output alu_fn, alu_a, alu_b,
        input  alu_res, alu_z, alu_v, alu_n,
        output busy
    );

    modport master (
        output r0_valid, r0_fn, r0_a, r0_b, r0_rsp_ready,
        output r1_valid, r1_fn, r1_a, r1_b, r1_rsp_ready,
        input  r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        input  rsp_data, rsp_z, rsp_v, rsp_n, rsp_err,
        input  alu_fn, alu_a, alu_b,
        output alu_res, alu_z, alu_v, alu_n,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters. One operation in flight: IDLE accepts, EXEC lets the ALU settle
// for one cycle and captures its result, RESP holds the result until the
// owning requester takes it.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       next_state;

    logic         prio;      // requester that wins a tie
    logic         owner;     // requester of the operation in flight
    logic         err_q;     // operation in flight carries an illegal fn
    logic         busy_q;

    logic [5:0]   alu_fn_q;
    logic [W-1:0] alu_a_q;
    logic [W-1:0] alu_b_q;

    logic [W-1:0] rsp_data_q;
    logic         rsp_z_q;
    logic         rsp_v_q;
    logic         rsp_n_q;
    logic         rsp_err_q;

    logic         grant;     // index of the requester that would win now
    logic         any_valid;
    logic         accept;
    logic         rsp_done;

    logic [5:0]   sel_fn;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;

    function automatic logic legal_fn(input logic [5:0] fn);
        case (fn)
            6'b000000, 6'b000001, 6'b000010,             // ADD SUB MUL
            6'b011000, 6'b011110, 6'b010110, 6'b011010,  // AND OR XOR A
            6'b100000, 6'b100001, 6'b100011,             // SHL SHR SRA
            6'b110011, 6'b110101, 6'b110111:             // CMPEQ CMPLT CMPLE
                legal_fn = 1'b1;
            default:
                legal_fn = 1'b0;
        endcase
    endfunction

    // Lone valid requester wins; on a tie prio decides.
    assign any_valid = bus.r0_valid | bus.r1_valid;
    assign grant     = (bus.r0_valid & bus.r1_valid) ? prio : bus.r1_valid;
    assign accept    = (state == IDLE) & any_valid;
    assign rsp_done  = (state == RESP) & (owner ? bus.r1_rsp_ready : bus.r0_rsp_ready);

    assign sel_fn = grant ? bus.r1_fn : bus.r0_fn;
    assign sel_a  = grant ? bus.r1_a  : bus.r0_a;
    assign sel_b  = grant ? bus.r1_b  : bus.r0_b;

    // State register and registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (accept)   next_state = EXEC;
            EXEC:                  next_state = RESP;
            RESP:    if (rsp_done) next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // Handshake outputs; ready is forced low while reset is asserted.
    always_comb begin
        bus.r0_ready     = 1'b0;
        bus.r1_ready     = 1'b0;
        bus.r0_rsp_valid = 1'b0;
        bus.r1_rsp_valid = 1'b0;
        if (state == IDLE && !reset) begin
            bus.r0_ready = bus.r0_valid & ~grant;
            bus.r1_ready = bus.r1_valid &  grant;
        end
        if (state == RESP) begin
            bus.r0_rsp_valid = ~owner;
            bus.r1_rsp_valid =  owner;
        end
    end

    // Operand capture on accept, result capture at the end of EXEC, prio update on response.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: datapath registers are reset too because their reset values are visible outputs.
        if (reset) begin
            prio       <= 1'b0;
            owner      <= 1'b0;
            err_q      <= 1'b0;
            alu_fn_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_z_q    <= 1'b0;
            rsp_v_q    <= 1'b0;
            rsp_n_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                alu_fn_q <= sel_fn;
                alu_a_q  <= sel_a;
                alu_b_q  <= sel_b;
                owner    <= grant;
                err_q    <= ~legal_fn(sel_fn);
            end
            if (state == EXEC) begin
                if (err_q) begin
                    rsp_data_q <= '0;
                    rsp_z_q    <= 1'b0;
                    rsp_v_q    <= 1'b0;
                    rsp_n_q    <= 1'b0;
                    rsp_err_q  <= 1'b1;
                end else begin
                    rsp_data_q <= bus.alu_res;
                    rsp_z_q    <= bus.alu_z;
                    rsp_v_q    <= bus.alu_v;
                    rsp_n_q    <= bus.alu_n;
                    rsp_err_q  <= 1'b0;
                end
            end
            if (rsp_done) begin
                prio <= ~owner;
            end
        end
    end

    assign bus.alu_fn   = alu_fn_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_z    = rsp_z_q;
    assign bus.rsp_v    = rsp_v_q;
    assign bus.rsp_n    = rsp_n_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed requests, a behavioural ALU on the
// ALU port, and a scoreboard queue drained by an independent monitor.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int W = 32;

    localparam logic [5:0] FN_ADD   = 6'b000000;
    localparam logic [5:0] FN_SUB   = 6'b000001;
    localparam logic [5:0] FN_AND   = 6'b011000;
    localparam logic [5:0] FN_OR    = 6'b011110;
    localparam logic [5:0] FN_XOR   = 6'b010110;
    localparam logic [5:0] FN_CMPEQ = 6'b110011;
    localparam logic [5:0] FN_BAD   = 6'b000111;

    typedef struct {
        bit           owner;
        logic [W-1:0] data;
        logic         z;
        logic         v;
        logic         n;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    alu_arbiter_if #(.W(W)) bus ();

    alu_arbiter #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; illegal codes yield a poison value the arbiter must mask.
    always_comb begin
        logic [W-1:0] r;
        r = 32'hdeadbeef;
        bus.alu_v = 1'b0;
        case (bus.alu_fn)
            FN_ADD: begin
                r = bus.alu_a + bus.alu_b;
                bus.alu_v = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (r[W-1] != bus.alu_a[W-1]);
            end
            FN_SUB: begin
                r = bus.alu_a - bus.alu_b;
                bus.alu_v = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (r[W-1] != bus.alu_a[W-1]);
            end
            FN_AND:   r = bus.alu_a & bus.alu_b;
            FN_OR:    r = bus.alu_a | bus.alu_b;
            FN_XOR:   r = bus.alu_a ^ bus.alu_b;
            FN_CMPEQ: r = {{(W-1){1'b0}}, bus.alu_a == bus.alu_b};
            default:  bus.alu_v = 1'b1;
        endcase
        bus.alu_res = r;
        bus.alu_z   = (r == '0) || (r == 32'hdeadbeef);
        bus.alu_n   = r[W-1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic expect_rsp(input bit owner, input logic [W-1:0] data,
                              input logic z, input logic v, input logic n, input logic err);
        exp_t e;
        e.owner = owner; e.data = data; e.z = z; e.v = v; e.n = n; e.err = err;
        sb.push_back(e);
    endtask

    // Present a request and hold it until accepted; returns 1ns after the accept edge.
    task automatic send(input bit p, input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        int  n = 0;
        bit  done = 0;
        @(negedge clk);
        if (p) begin
            bus.r1_valid = 1'b1; bus.r1_fn = fn; bus.r1_a = a; bus.r1_b = b;
        end else begin
            bus.r0_valid = 1'b1; bus.r0_fn = fn; bus.r0_a = a; bus.r0_b = b;
        end
        while (!done) begin
            #1;
            if (p ? bus.r1_ready : bus.r0_ready) begin
                done = 1;
            end else if (n > 60) begin
                timeout(p ? "r1_accept" : "r0_accept");
                done = 1;
            end else begin
                n++;
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        if (p) bus.r1_valid = 1'b0;
        else   bus.r0_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout(name);
    endtask

    task automatic wait_rsp_valid(input bit p, input string name);
        int n = 0;
        while (!(p ? bus.r1_rsp_valid : bus.r0_rsp_valid) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) timeout(name);
    endtask

    // Monitor: compare every response handshake against the scoreboard head.
    initial begin
        exp_t e;
        bit   p;
        forever begin
            @(negedge clk);
            #1;
            if (bus.r0_rsp_valid || bus.r1_rsp_valid)
                check("rsp_valid_onehot", {63'd0, bus.r0_rsp_valid & bus.r1_rsp_valid}, 64'd0);
            if ((bus.r0_rsp_valid && bus.r0_rsp_ready) || (bus.r1_rsp_valid && bus.r1_rsp_ready)) begin
                p = bus.r1_rsp_valid;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: r%0d data 0x%0h with nothing expected", p, bus.rsp_data);
                end else begin
                    e = sb.pop_front();
                    check("rsp_owner", {63'd0, p}, {63'd0, e.owner});
                    check("rsp_data",  {32'd0, bus.rsp_data}, {32'd0, e.data});
                    check("rsp_flags", {60'd0, bus.rsp_z, bus.rsp_v, bus.rsp_n, bus.rsp_err},
                                       {60'd0, e.z, e.v, e.n, e.err});
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.r0_valid = 1'b1; bus.r0_fn = FN_ADD; bus.r0_a = '0; bus.r0_b = '0;
        bus.r1_valid = 1'b1; bus.r1_fn = FN_ADD; bus.r1_a = '0; bus.r1_b = '0;
        bus.r0_rsp_ready = 1'b1;
        bus.r1_rsp_ready = 1'b1;

        // Reset values, with both requesters valid.
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", {62'd0, bus.r0_ready, bus.r1_ready}, 64'd0);
        check("reset_rsp_valid", {62'd0, bus.r0_rsp_valid, bus.r1_rsp_valid}, 64'd0);
        check("reset_rsp", {28'd0, bus.rsp_data, bus.rsp_z, bus.rsp_v, bus.rsp_n, bus.rsp_err}, 64'd0);
        check("reset_alu", {bus.alu_a, bus.alu_b} | {58'd0, bus.alu_fn}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single ADD on r0 with latency checks.
        expect_rsp(0, 32'h0000000C, 0, 0, 0, 0);
        send(0, FN_ADD, 32'd5, 32'd7);
        check("add_alu_fn", {58'd0, bus.alu_fn}, {58'd0, FN_ADD});
        check("add_alu_ops", {bus.alu_a, bus.alu_b}, {32'd5, 32'd7});
        check("add_busy_exec", {63'd0, bus.busy}, 64'd1);
        check("add_no_rsp_in_exec", {63'd0, bus.r0_rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("add_rsp_latency", {63'd0, bus.r0_rsp_valid}, 64'd1);
        wait_idle("add_drain");

        // SUB on r1; r0 must stay silent.
        expect_rsp(1, 32'h000000CC, 0, 0, 0, 0);
        send(1, FN_SUB, 32'h00000000, 32'hffffff34);
        wait_rsp_valid(1, "sub_rsp");
        check("sub_r0_rsp_quiet", {63'd0, bus.r0_rsp_valid}, 64'd0);
        wait_idle("sub_drain");

        // Simultaneous pairs: r0 first each time since prio returns to 0.
        expect_rsp(0, 32'h00000001, 0, 0, 0, 0);
        expect_rsp(1, 32'hffffff20, 0, 0, 1, 0);
        fork
            send(0, FN_CMPEQ, 32'h0a0a0a0a, 32'h0a0a0a0a);
            send(1, FN_AND,   32'hffffff68, 32'hffffff34);
        join
        wait_idle("pair1_drain");

        expect_rsp(0, 32'h0f0f00f0, 0, 0, 0, 0);
        expect_rsp(1, 32'hf0f0f0f0, 0, 0, 1, 0);
        fork
            send(0, FN_OR,  32'h0f0f0000, 32'h000000f0);
            send(1, FN_XOR, 32'hff00ff00, 32'h0ff00ff0);
        join
        wait_idle("pair2_drain");

        // Response backpressure on r0 while r1 waits.
        bus.r0_rsp_ready = 1'b0;
        expect_rsp(0, 32'h00000030, 0, 0, 0, 0);
        expect_rsp(1, 32'hffffffff, 0, 0, 1, 0);
        send(0, FN_ADD, 32'h10, 32'h20);
        fork
            send(1, FN_SUB, 32'd9, 32'd10);
            begin
                wait_rsp_valid(0, "bp_rsp");
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    check("bp_hold_data", {32'd0, bus.rsp_data}, 64'h30);
                    check("bp_hold_valid_flags",
                          {59'd0, bus.r0_rsp_valid, bus.rsp_z, bus.rsp_v, bus.rsp_n, bus.rsp_err}, 64'h10);
                    check("bp_r1_ready", {63'd0, bus.r1_ready}, 64'd0);
                    check("bp_busy", {63'd0, bus.busy}, 64'd1);
                end
                @(negedge clk);
                bus.r0_rsp_ready = 1'b1;
            end
        join
        wait_idle("bp_drain");

        // Illegal fn: error response with the normal latency.
        expect_rsp(0, 32'h0, 0, 0, 0, 1);
        send(0, FN_BAD, 32'd3, 32'd4);
        check("err_no_rsp_in_exec", {63'd0, bus.r0_rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("err_rsp_latency", {63'd0, bus.r0_rsp_valid}, 64'd1);
        wait_idle("err_drain");

        // Reset during EXEC discards the operation.
        send(1, FN_ADD, 32'd1, 32'd2);
        bus.r0_valid = 1'b1; bus.r0_fn = FN_ADD; bus.r0_a = 32'd8; bus.r0_b = 32'd8;
        reset = 1'b1;
        #1;
        check("mid_reset_ready", {62'd0, bus.r0_ready, bus.r1_ready}, 64'd0);
        check("mid_reset_rsp_valid", {62'd0, bus.r0_rsp_valid, bus.r1_rsp_valid}, 64'd0);
        check("mid_reset_alu", {bus.alu_a, bus.alu_b} | {58'd0, bus.alu_fn}, 64'd0);
        check("mid_reset_rsp", {28'd0, bus.rsp_data, bus.rsp_z, bus.rsp_v, bus.rsp_n, bus.rsp_err}, 64'd0);
        check("mid_reset_busy", {63'd0, bus.busy}, 64'd0);
        bus.r0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("post_reset_quiet", {62'd0, bus.r0_rsp_valid, bus.r1_rsp_valid}, 64'd0);
        end

        // Normal service resumes, including a signed-overflow ADD.
        expect_rsp(0, 32'h00ffff00, 0, 0, 0, 0);
        send(0, FN_OR, 32'h00ff0000, 32'h0000ff00);
        wait_idle("post_reset_drain");
        expect_rsp(1, 32'h80000000, 0, 1, 1, 0);
        send(1, FN_ADD, 32'h7fffffff, 32'h00000001);
        wait_idle("ovf_drain");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
